// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a fixed-latency system memory.
// Alternating priority on ties; one transaction in flight at a time; all outputs registered.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iStrobe,
    input  logic              iRw,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [DATA_W-1:0] iWdata,
    output logic              iReady,
    output logic [DATA_W-1:0] iRdata,
    input  logic              dStrobe,
    input  logic              dRw,
    input  logic [ADDR_W-1:0] dAddress,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dReady,
    output logic [DATA_W-1:0] dRdata,
    output logic              SysStrobe,
    output logic              SysRW,
    output logic [ADDR_W-1:0] SysAddress,
    output logic [DATA_W-1:0] SysWdata,
    input  logic [DATA_W-1:0] SysRdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    localparam logic       GNT_I  = 1'b0;
    localparam logic       GNT_D  = 1'b1;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;   // also the grant flag of the running transaction
    logic [3:0]          cnt_q, cnt_d;
    logic                sys_strobe_q, sys_strobe_d;
    logic                sys_rw_q, sys_rw_d;
    logic [ADDR_W-1:0]   sys_addr_q, sys_addr_d;
    logic [DATA_W-1:0]   sys_wdata_q, sys_wdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                busy_q, busy_d;
    logic                win_s;

    // Winner selection: a lone strobe wins, a tie goes to the side not granted last.
    always_comb begin
        win_s = GNT_I;
        if (iStrobe && dStrobe) begin
            win_s = ~last_grant_q;
        end else if (dStrobe) begin
            win_s = GNT_D;
        end else begin
            win_s = GNT_I;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        sys_strobe_d = 1'b0;
        sys_rw_d     = sys_rw_q;
        sys_addr_d   = sys_addr_q;
        sys_wdata_d  = sys_wdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (iStrobe || dStrobe) begin
                    state_d      = ISSUE;
                    last_grant_d = win_s;
                    sys_strobe_d = 1'b1;
                    sys_rw_d     = (win_s == GNT_D) ? dRw      : iRw;
                    sys_addr_d   = (win_s == GNT_D) ? dAddress : iAddress;
                    sys_wdata_d  = (win_s == GNT_D) ? dWdata   : iWdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = DONE;
                    i_ready_d = (last_grant_q == GNT_I);
                    d_ready_d = (last_grant_q == GNT_D);
                    if (sys_rw_q && (last_grant_q == GNT_D)) begin
                        d_rdata_d = SysRdata;
                    end else if (sys_rw_q) begin
                        i_rdata_d = SysRdata;
                    end else begin
                        i_rdata_d = i_rdata_q;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_D;
            cnt_q        <= 4'd0;
            sys_strobe_q <= 1'b0;
            sys_rw_q     <= 1'b0;
            sys_addr_q   <= {ADDR_W{1'b0}};
            sys_wdata_q  <= {DATA_W{1'b0}};
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            sys_strobe_q <= sys_strobe_d;
            sys_rw_q     <= sys_rw_d;
            sys_addr_q   <= sys_addr_d;
            sys_wdata_q  <= sys_wdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign SysStrobe  = sys_strobe_q;
    assign SysRW      = sys_rw_q;
    assign SysAddress = sys_addr_q;
    assign SysWdata   = sys_wdata_q;
    assign iReady     = i_ready_q;
    assign dReady     = d_ready_q;
    assign iRdata     = i_rdata_q;
    assign dRdata     = d_rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model, directed scenarios with literal
// expectations, randomized traffic with mid-transaction resets, plus latency-1/15 instances.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  act, rw_r, done;
    logic [31:0] addr_r [2];
    logic [31:0] wd_r   [2];
    logic [31:0] sys_rdata;
    logic        i_ready, d_ready, sys_stb, sys_rw, busy;
    logic [31:0] i_rdata, d_rdata, sys_addr, sys_wd;

    logic        l1_stb, l15_stb, l1_seen, l15_seen;
    logic        l1_ir, l15_ir, l1_dr, l15_dr, l1_ss, l15_ss, l1_srw, l15_srw, l1_busy, l15_busy;
    logic [31:0] l1_ird, l15_ird, l1_drd, l15_drd, l1_sa, l15_sa, l1_sw, l15_sw;

    // transaction-timeline model
    bit          m_busy, m_win, m_lastg, m_rw;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;
    int          m_t0, cyc, rd_cyc;
    bit          rnd_mode, rep;
    int          checks, failures;

    logic        h_sstb [512], h_srw [512], h_ir [512], h_dr [512], h1_ir [512], h15_ir [512];
    logic [31:0] h_saddr [512], h_swd [512], h_ird [512], h_drd [512];

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .iStrobe(act[0]), .iRw(rw_r[0]), .iAddress(addr_r[0]), .iWdata(wd_r[0]),
        .iReady(i_ready), .iRdata(i_rdata),
        .dStrobe(act[1]), .dRw(rw_r[1]), .dAddress(addr_r[1]), .dWdata(wd_r[1]),
        .dReady(d_ready), .dRdata(d_rdata),
        .SysStrobe(sys_stb), .SysRW(sys_rw), .SysAddress(sys_addr), .SysWdata(sys_wd),
        .SysRdata(sys_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .iStrobe(l1_stb), .iRw(1'b1), .iAddress(32'h0000_0040), .iWdata(32'd0),
        .iReady(l1_ir), .iRdata(l1_ird),
        .dStrobe(1'b0), .dRw(1'b0), .dAddress(32'd0), .dWdata(32'd0),
        .dReady(l1_dr), .dRdata(l1_drd),
        .SysStrobe(l1_ss), .SysRW(l1_srw), .SysAddress(l1_sa), .SysWdata(l1_sw),
        .SysRdata(32'hC0FF_EE01), .busy(l1_busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
        .clock(clock), .reset(reset),
        .iStrobe(l15_stb), .iRw(1'b1), .iAddress(32'h0000_0080), .iWdata(32'd0),
        .iReady(l15_ir), .iRdata(l15_ird),
        .dStrobe(1'b0), .dRw(1'b0), .dAddress(32'd0), .dWdata(32'd0),
        .dReady(l15_dr), .dRdata(l15_drd),
        .SysStrobe(l15_ss), .SysRW(l15_srw), .SysAddress(l15_sa), .SysWdata(l15_sw),
        .SysRdata(32'hC0FF_EE0F), .busy(l15_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    task automatic compare_cycle();
        int p;
        p = cyc - m_t0;
        chk("SysStrobe", 32'(sys_stb), 32'(m_busy && p == 1));
        chk("busy",      32'(busy),    32'(m_busy));
        chk("iReady",    32'(i_ready), 32'(m_busy && p == LAT + 2 && !m_win));
        chk("dReady",    32'(d_ready), 32'(m_busy && p == LAT + 2 && m_win));
        chk("SysRW",     32'(sys_rw),  32'(m_rw));
        chk("SysAddress", sys_addr, m_addr);
        chk("SysWdata",   sys_wd,   m_wdata);
        chk("iRdata",     i_rdata,  m_ird);
        chk("dRdata",     d_rdata,  m_drd);
        chk("aux_dReady", 32'(l1_dr | l15_dr), 32'd0);
        if (cyc < 512) begin
            h_sstb[cyc] = sys_stb;  h_srw[cyc] = sys_rw;  h_ir[cyc] = i_ready; h_dr[cyc] = d_ready;
            h_saddr[cyc] = sys_addr; h_swd[cyc] = sys_wd; h_ird[cyc] = i_rdata; h_drd[cyc] = d_rdata;
            h1_ir[cyc] = l1_ir; h15_ir[cyc] = l15_ir;
        end
        if (l1_ir)  l1_seen  = 1'b1;
        if (l15_ir) l15_seen = 1'b1;
    endtask

    task automatic model_update();
        int p;
        p = cyc - m_t0;
        if (m_busy) begin
            if (p == LAT + 1 && m_rw) begin
                if (m_win) m_drd = sys_rdata;
                else       m_ird = sys_rdata;
            end
            if (p == LAT + 2) begin
                m_busy = 1'b0;
                done[m_win] = 1'b1;
            end
        end else if (act != 2'b00) begin
            m_win   = (act == 2'b11) ? ~m_lastg : act[1];
            m_lastg = m_win;
            m_rw    = rw_r[m_win];
            m_addr  = addr_r[m_win];
            m_wdata = wd_r[m_win];
            m_t0    = cyc;
            m_busy  = 1'b1;
        end
    endtask

    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            if (done[s]) begin
                act[s]  = rep;
                done[s] = 1'b0;
            end
            if (!act[s]) begin
                if (rnd_mode && $urandom_range(0, 2) == 0) act[s] = 1'b1;
                rw_r[s]   = 1'($urandom_range(0, 1));
                addr_r[s] = $urandom;
                wd_r[s]   = $urandom;
            end
        end
        sys_rdata = rnd_mode ? $urandom : ((cyc == rd_cyc) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD);
        if (l1_seen)  l1_stb  = 1'b0;
        if (l15_seen) l15_stb = 1'b0;
    endtask

    task automatic step();
        @(negedge clock);
        compare_cycle();
        model_update();
        @(posedge clock);
        #1;
        cyc++;
        drive();
    endtask

    task automatic reset_and_release();
        reset = 1'b0;
        #1;
        chk("rst_outputs", {sys_stb, sys_rw, i_ready, d_ready, busy}, 32'd0);
        chk("rst_data", sys_addr | sys_wd | i_rdata | d_rdata, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        m_busy = 1'b0; m_lastg = 1'b1; m_win = 1'b0; m_rw = 1'b0; m_t0 = 0;
        m_addr = 32'd0; m_wdata = 32'd0; m_ird = 32'd0; m_drd = 32'd0;
        act = 2'b00; done = 2'b00; rep = 1'b0; cyc = 0;
        l1_stb = 1'b0; l15_stb = 1'b0; l1_seen = 1'b0; l15_seen = 1'b0;
        drive();
    endtask

    task automatic abort_in_wait();
        int n;
        n = 0;
        while (!(m_busy && (cyc - m_t0) >= 2 && (cyc - m_t0) <= LAT + 1) && n < 60) begin
            step();
            n++;
        end
        chk("reach_wait", 32'(n < 60), 32'd1);
        reset_and_release();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        logic any_dr;
        checks = 0; failures = 0; rnd_mode = 1'b0; rd_cyc = -1;
        act = 2'b00; rw_r = 2'b00; done = 2'b00; sys_rdata = 32'd0;
        addr_r[0] = 32'd0; addr_r[1] = 32'd0; wd_r[0] = 32'd0; wd_r[1] = 32'd0;
        l1_stb = 1'b0; l15_stb = 1'b0; l1_seen = 1'b0; l15_seen = 1'b0;
        reset_and_release();

        // first tie after reset, then repeated ties
        b = cyc;
        act = 2'b11; rw_r = 2'b11; rep = 1'b1;
        addr_r[0] = 32'h0000_00A0; addr_r[1] = 32'h0000_00B0;
        wd_r[0] = 32'd0; wd_r[1] = 32'd0;
        repeat (17) step();
        rep = 1'b0;
        chk("tie1_sstb",  32'(h_sstb[b + 1]),  32'd1);
        chk("tie1_addr",  h_saddr[b + 1],      32'h0000_00A0);
        chk("tie1_iready", 32'(h_ir[b + 4]),   32'd1);
        chk("tie_gap_sstb", 32'(h_sstb[b + 5]), 32'd0);
        chk("tie2_sstb",  32'(h_sstb[b + 6]),  32'd1);
        chk("tie2_addr",  h_saddr[b + 6],      32'h0000_00B0);
        chk("tie2_dready", 32'(h_dr[b + 9]),   32'd1);
        chk("tie3_addr",  h_saddr[b + 11],     32'h0000_00A0);
        chk("tie4_addr",  h_saddr[b + 16],     32'h0000_00B0);
        repeat (15) step();

        // single instruction read, plus latency-1 and latency-15 instances
        b = cyc;
        act[0] = 1'b1; rw_r[0] = 1'b1; addr_r[0] = 32'h0000_0010; wd_r[0] = 32'd0;
        rd_cyc = b + 3;
        l1_stb = 1'b1; l15_stb = 1'b1; l1_seen = 1'b0; l15_seen = 1'b0;
        repeat (20) step();
        any_dr = 1'b0;
        for (int k = 0; k < 20; k++) any_dr = any_dr | h_dr[b + k];
        chk("rd_sstb_c0",  32'(h_sstb[b]),     32'd0);
        chk("rd_sstb_c1",  32'(h_sstb[b + 1]), 32'd1);
        chk("rd_addr_c1",  h_saddr[b + 1],     32'h0000_0010);
        chk("rd_iready_c3", 32'(h_ir[b + 3]),  32'd0);
        chk("rd_iready_c4", 32'(h_ir[b + 4]),  32'd1);
        chk("rd_irdata_c4", h_ird[b + 4],      32'hDEAD_BEEF);
        chk("rd_dready_never", 32'(any_dr),    32'd0);
        chk("model_ird",   m_ird,              32'hDEAD_BEEF);
        chk("lat1_early",  32'(h1_ir[b + 2]),  32'd0);
        chk("lat1_ready",  32'(h1_ir[b + 3]),  32'd1);
        chk("lat15_early", 32'(h15_ir[b + 16]), 32'd0);
        chk("lat15_ready", 32'(h15_ir[b + 17]), 32'd1);
        chk("lat1_rdata",  l1_ird,  32'hC0FF_EE01);
        chk("lat15_rdata", l15_ird, 32'hC0FF_EE0F);
        chk("lat_sysaddr", l1_sa | l15_sa, 32'h0000_00C0);
        chk("lat_misc", {l1_ss, l15_ss, l1_busy, l15_busy, ~l1_srw, ~l15_srw}, 32'd0);
        chk("lat_zero", l1_drd | l15_drd | l1_sw | l15_sw, 32'd0);

        // data-side write leaves both read registers untouched
        b = cyc;
        act[1] = 1'b1; rw_r[1] = 1'b0; addr_r[1] = 32'h0000_0100; wd_r[1] = 32'h1234_5678;
        repeat (7) step();
        chk("wr_sstb",   32'(h_sstb[b + 1]), 32'd1);
        chk("wr_sysrw",  32'(h_srw[b + 1]),  32'd0);
        chk("wr_addr",   h_saddr[b + 1],     32'h0000_0100);
        chk("wr_wdata",  h_swd[b + 1],       32'h1234_5678);
        chk("wr_dready", 32'(h_dr[b + 4]),   32'd1);
        chk("wr_drdata", h_drd[b + 4],       32'h0BAD_0BAD);
        chk("wr_irdata", h_ird[b + 4],       32'hDEAD_BEEF);

        // randomized traffic with resets landing in WAIT
        rnd_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (i == 200 || i == 400) abort_in_wait();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requester and system ports.
REQ-002 Parameter: DATA_W, 32, data width of requester and system ports.
REQ-003 Parameter: MEM_LAT, 2, fixed system-memory read/write latency in cycles; legal range 1..15.
REQ-004 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 iStrobe  input  1  instruction-side request.
REQ-007 iRw  input  1  instruction-side direction: 1 = read, 0 = write.
REQ-008 iAddress  input  ADDR_W  instruction-side address.
REQ-009 iWdata  input  DATA_W  instruction-side write data.
REQ-010 iReady  output  1  instruction-side completion pulse.
REQ-011 iRdata  output  DATA_W  instruction-side read data.
REQ-012 dStrobe, dRw, dAddress, dWdata, dReady, dRdata SHALL be the data-side ports, with the same directions, widths and meanings as REQ-006..011.
REQ-013 SysStrobe  output  1  system-memory command strobe.
REQ-014 SysRW  output  1  system-memory direction: 1 = read, 0 = write.
REQ-015 SysAddress  output  ADDR_W  system-memory address.
REQ-016 SysWdata  output  DATA_W  system-memory write data.
REQ-017 SysRdata  input  DATA_W  system-memory read data; valid in the last WAIT cycle.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 Requester protocol: the requester SHALL hold Strobe, Rw, Address and Wdata stable from assertion until its Ready pulse is seen.
REQ-020 Strobe still high in the cycle after Ready SHALL be treated as a new request.
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE; all outputs SHALL be registered.
REQ-022 IDLE: with no strobe, the FSM SHALL remain in IDLE.
REQ-023 IDLE: with any strobe, the arbiter SHALL select a winner, latch the winner's Rw, Address and Wdata plus a grant flag, and go to ISSUE.
REQ-024 Arbitration: a single requester SHALL win; with both strobes high, the requester not granted last (last_grant) SHALL win; last_grant SHALL update on every grant.
REQ-025 ISSUE (exactly 1 cycle): SysStrobe SHALL be 1 and SysRW/SysAddress/SysWdata SHALL drive the latched values; the latency counter SHALL load MEM_LAT-1; next state SHALL be WAIT.
REQ-026 WAIT: SysStrobe SHALL be 0 and SysRW/SysAddress/SysWdata SHALL hold; the counter SHALL decrement each cycle.
REQ-027 WAIT exit: in the cycle the counter equals 0, a read SHALL capture SysRdata into the granted side's Rdata and the FSM SHALL go to DONE; WAIT therefore SHALL last exactly MEM_LAT cycles.
REQ-028 DONE (exactly 1 cycle): the granted side's Ready SHALL be 1 and the other side's Ready SHALL be 0; next state SHALL be IDLE.
REQ-029 Latency: a strobe first sampled in IDLE at cycle N SHALL produce Ready at cycle N+2+MEM_LAT.
REQ-030 Writes SHALL produce a Ready pulse and SHALL leave both Rdata registers unchanged.
REQ-031 Each Rdata SHALL hold its value until the next read completion for that side.
REQ-032 A losing or late strobe SHALL be ignored until IDLE and SHALL not be dropped; requests SHALL never preempt a transaction in progress.
REQ-033 iReady and dReady SHALL never both be 1; SysStrobe SHALL be 1 only in ISSUE.

Reset
REQ-034 On reset low, asynchronously: state SHALL be IDLE.
REQ-035 On reset low, asynchronously: SysStrobe, SysRW, iReady, dReady and busy SHALL be 0.
REQ-036 On reset low, asynchronously: SysAddress, SysWdata, iRdata, dRdata and the counter SHALL be 0.
REQ-037 On reset low, asynchronously: last_grant SHALL be set to data, so the first tie goes to instruction.
REQ-038 Reset mid-transaction SHALL abort the transaction with no Ready pulse; the first request after reset release SHALL start from IDLE.

Verification
REQ-039 Scenario: MEM_LAT=2, iStrobe read 0x0000_0010 at cycle 0, SysRdata=0xDEAD_BEEF in the WAIT exit cycle -> SysStrobe=1 in cycle 1, iReady=1 in cycle 4, iRdata=0xDEAD_BEEF, dReady=0 throughout.
REQ-040 Scenario: first tie after reset, iStrobe and dStrobe both high -> instruction served first, data served next (SysStrobe again in the cycle after the IDLE that follows DONE).
REQ-041 Scenario: repeated ties -> grants alternate I, D, I, D with no starvation.
REQ-042 Scenario: dStrobe write, address 0x0000_0100, data 0x1234_5678 -> SysRW=0 with that address/data in ISSUE, dReady pulse, dRdata unchanged.
REQ-043 Scenario: reset asserted during WAIT -> all outputs 0 immediately, no Ready; a fresh read after release completes with the normal latency.
REQ-044 Scenario: MEM_LAT=1 and MEM_LAT=15 -> Ready arrives exactly 3 and 17 cycles after the strobe respectively.
